// File: rtl/mux_scan_sequencer_if.sv
// Bundle of the upstream word handshake, the downstream 16:1 mux drive/return
// and the result handshake of the mux scan sequencer.
interface mux_scan_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] mux_data;
  logic [3:0]  mux_sel;
  logic        mux_en;
  logic        mux_out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_errcnt;

  // The sequencer itself is the slave; the environment around it is the master.
  modport slave (
    input  in_valid, in_data, mux_out, out_ready,
    output in_ready, mux_data, mux_sel, mux_en, out_valid, out_data, out_errcnt
  );

  modport master (
    output in_valid, in_data, mux_out, out_ready,
    input  in_ready, mux_data, mux_sel, mux_en, out_valid, out_data, out_errcnt
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Drives a captured word into an external 16:1 mux, walks the select through all
// inputs (with optional settle cycles per select) and returns the sampled bits.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  mux_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam bit         HAS_WAIT  = (SETTLE != 0);
  localparam logic [1:0] WAIT_LAST = 2'((SETTLE != 0) ? SETTLE - 1 : 0);
  localparam state_t     STEP_ST   = HAS_WAIT ? WAIT : SCAN;

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [15:0] data_q, data_d;
  logic [15:0] odata_q, odata_d;
  logic [4:0]  err_q, err_d;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= 5'd16) ? 5'd16 : v + 5'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      wcnt_q  <= 2'd0;
      data_q  <= 16'd0;
      odata_q <= 16'd0;
      err_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      odata_q <= odata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    odata_d = odata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          sel_d   = 4'd0;
          wcnt_d  = 2'd0;
          odata_d = 16'd0;
          err_d   = 5'd0;
          state_d = STEP_ST;
        end
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          wcnt_d  = 2'd0;
          state_d = SCAN;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      SCAN: begin
        odata_d[sel_q] = bus.mux_out;
        if (bus.mux_out != data_q[sel_q]) begin
          err_d = sat_inc(err_q);
        end
        // The last select is held so the mux input stays put while the result waits.
        if (sel_q == 4'd15) begin
          state_d = DONE;
        end else begin
          sel_d   = sel_q + 4'd1;
          state_d = STEP_ST;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.mux_en     = (state_q == SCAN) || (state_q == WAIT);
  assign bus.mux_sel    = sel_q;
  assign bus.mux_data   = data_q;
  assign bus.out_data   = odata_q;
  assign bus.out_errcnt = err_q;

endmodule
